// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter. Words pushed on wr_en are
// queued and sent back-to-back on tx with build-time data width, parity,
// stop-bit count and baud divisor.
module uart_tx_fifo #(
  parameter int unsigned BAUD_DIV   = 1250,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        wr_en,
  input  logic [DATA_BITS-1:0]        wr_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow,
  output logic                        busy,
  output logic                        tx
);

  localparam int unsigned      PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned      CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]      BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  // Elaboration-time rejection of illegal parameter values.
  if (BAUD_DIV < 2 || BAUD_DIV > 65535 ||
      DATA_BITS < 5 || DATA_BITS > 8 ||
      PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || FIFO_DEPTH > 256 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_tx_fifo: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 overflow_q, overflow_d;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  // Transmit FSM state
  state_e               state_q, state_d;
  logic [15:0]          baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 baud_tick;

  assign head = mem_q[rd_ptr_q];

  // Next-state logic for the transmitter, including when to pop the FIFO.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    sh_d      = sh_q;
    par_d     = par_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    pop       = 1'b0;
    baud_tick = (baud_q == '0);

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (!empty_q) begin
          pop = 1'b1;
        end
      end

      S_START: begin
        if (baud_tick) begin
          state_d = S_DATA;
          baud_d  = BAUD_LAST;
          bit_d   = '0;
          tx_d    = sh_q[0];
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end

      S_DATA: begin
        if (baud_tick) begin
          baud_d = BAUD_LAST;
          if (bit_q == BIT_LAST) begin
            if (PARITY != 0) begin
              state_d = S_PAR;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              stop_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end else begin
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end

      S_PAR: begin
        if (baud_tick) begin
          state_d = S_STOP;
          baud_d  = BAUD_LAST;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end

      S_STOP: begin
        if (baud_tick) begin
          baud_d = BAUD_LAST;
          if (stop_q == STOP_LAST) begin
            if (!empty_q) begin
              pop = 1'b1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // A pop from IDLE or from the final stop clock starts the next frame
    // directly, so consecutive frames have no idle gap.
    if (pop) begin
      sh_d    = head;
      par_d   = (PARITY == 1) ? ~^head : ^head;
      state_d = S_START;
      baud_d  = BAUD_LAST;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
    end
  end

  // Transmitter registers; tx and busy are registered FSM outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // FIFO pointer, occupancy and flag update; full_q gates the push.
  always_comb begin
    push       = wr_en && !full_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || (wr_en && full_q);
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
  end

  // FIFO control registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage write; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: two transmitter builds (8N1 depth 4, 7E2 depth 8) driven
// by directed and random writes and compared every clock with a queue-based
// frame model.
module tb_uart_tx_fifo;

  localparam int B      = 4;
  localparam int DEPTH0 = 4;
  localparam int DEPTH1 = 8;

  logic       clk      = 1'b0;
  logic       rstn     = 1'b1;
  logic       wr_en0   = 1'b0;
  logic [7:0] wr_data0 = '0;
  logic       wr_en1   = 1'b0;
  logic [6:0] wr_data1 = '0;

  logic       full0, empty0, overflow0, busy0, tx0;
  logic [2:0] count0;
  logic       full1, empty1, overflow1, busy1, tx1;
  logic [3:0] count1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .BAUD_DIV(B), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH0)
  ) u_dut0 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en0), .wr_data(wr_data0),
    .full(full0), .empty(empty0), .count(count0), .overflow(overflow0),
    .busy(busy0), .tx(tx0)
  );

  uart_tx_fifo #(
    .BAUD_DIV(B), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH1)
  ) u_dut1 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en1), .wr_data(wr_data1),
    .full(full1), .empty(empty1), .count(count1), .overflow(overflow1),
    .busy(busy1), .tx(tx1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int db_of(int d);    return (d == 0) ? 8 : 7;           endfunction
  function automatic int par_of(int d);   return (d == 0) ? 0 : 2;           endfunction
  function automatic int sb_of(int d);    return (d == 0) ? 1 : 2;           endfunction
  function automatic int depth_of(int d); return (d == 0) ? DEPTH0 : DEPTH1; endfunction

  function automatic int frame_len(int d);
    return (1 + db_of(d) + ((par_of(d) != 0) ? 1 : 0) + sb_of(d)) * B;
  endfunction

  // Line level of bit k of the frame carrying word w.
  function automatic int frame_bit(int d, int w, int k);
    int n;
    int ones;
    n    = db_of(d);
    ones = $countones(w & ((1 << n) - 1));
    if (k == 0) return 0;
    if (k <= n) return (w >> (k - 1)) & 1;
    if (par_of(d) == 2 && k == n + 1) return ones % 2;
    if (par_of(d) == 1 && k == n + 1) return 1 - (ones % 2);
    return 1;
  endfunction

  int m_fifo [2][256];
  int m_head [2];
  int m_size [2];
  int m_rem  [2];   // clocks of the current frame still to appear on tx
  int m_cur  [2];
  int m_ovf  [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_head[d] = 0;
      m_size[d] = 0;
      m_rem[d]  = 0;
      m_cur[d]  = 0;
      m_ovf[d]  = 0;
    end
  endtask

  task automatic model_step(input int d, input logic en, input int data);
    int pre;
    bit do_pop;
    pre    = m_size[d];
    do_pop = (m_rem[d] <= 1) && (pre > 0);
    if (en) begin
      if (pre < depth_of(d)) begin
        m_fifo[d][(m_head[d] + pre) % 256] = data;
        m_size[d]++;
      end else begin
        m_ovf[d] = 1;
      end
    end
    if (do_pop) begin
      m_cur[d]  = m_fifo[d][m_head[d]];
      m_head[d] = (m_head[d] + 1) % 256;
      m_size[d]--;
      m_rem[d]  = frame_len(d);
    end else if (m_rem[d] > 0) begin
      m_rem[d]--;
    end
  endtask

  function automatic int exp_tx(int d);
    if (m_rem[d] == 0) return 1;
    return frame_bit(d, m_cur[d], (frame_len(d) - m_rem[d]) / B);
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      model_reset();
    end else begin
      model_step(0, wr_en0, int'(wr_data0));
      model_step(1, wr_en1, int'(wr_data1));
    end
  end

  // Per-clock comparison of every output against the model.
  always @(negedge clk) begin
    check("tx0",    32'(tx0),       exp_tx(0));
    check("busy0",  32'(busy0),     32'(m_rem[0] > 0));
    check("count0", 32'(count0),    m_size[0]);
    check("full0",  32'(full0),     32'(m_size[0] == DEPTH0));
    check("empty0", 32'(empty0),    32'(m_size[0] == 0));
    check("ovf0",   32'(overflow0), m_ovf[0]);
    check("tx1",    32'(tx1),       exp_tx(1));
    check("busy1",  32'(busy1),     32'(m_rem[1] > 0));
    check("count1", 32'(count1),    m_size[1]);
    check("full1",  32'(full1),     32'(m_size[1] == DEPTH1));
    check("empty1", 32'(empty1),    32'(m_size[1] == 0));
    check("ovf1",   32'(overflow1), m_ovf[1]);
  end

  task automatic idle_wait(input int lim);
    int n;
    n = 0;
    while ((busy0 || !empty0 || busy1 || !empty1) && n < lim) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 32'(n < lim), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int nb0, nb1, line0, line1, min_cnt, low_cnt;

    #1 rstn = 1'b0;
    #2;
    check("rst_tx0",    32'(tx0),       1);
    check("rst_busy0",  32'(busy0),     0);
    check("rst_empty0", 32'(empty0),    1);
    check("rst_full0",  32'(full0),     0);
    check("rst_count0", 32'(count0),    0);
    check("rst_ovf0",   32'(overflow0), 0);
    check("rst_tx1",    32'(tx1),       1);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // Single frames: 0x21 as 8N1, 0x41 as 7E2.
    wr_en0 = 1'b1; wr_data0 = 8'h21;
    wr_en1 = 1'b1; wr_data1 = 7'h41;
    @(negedge clk);
    wr_en0 = 1'b0; wr_en1 = 1'b0;
    check("lat_push_tx0",  32'(tx0),    1);
    check("lat_push_cnt0", 32'(count0), 1);
    @(negedge clk);
    check("lat_pop_tx0",   32'(tx0),    0);
    check("lat_pop_busy0", 32'(busy0),  1);
    nb0 = 0; nb1 = 0; line0 = 0; line1 = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy0) nb0++;
      if (busy1) nb1++;
      if (i % 4 == 1 && i < 40) line0 |= int'(tx0) << (i / 4);
      if (i % 4 == 1 && i < 44) line1 |= int'(tx1) << (i / 4);
      @(negedge clk);
    end
    check("busy_len0", nb0, 40);
    check("busy_len1", nb1, 44);
    check("line0",     line0, 32'h242);
    check("line1",     line1, 32'h682);
    check("end_tx0",   32'(tx0),    1);
    check("end_empty0", 32'(empty0), 1);

    // Back-to-back frames.
    wr_en0 = 1'b1; wr_data0 = 8'h55;
    @(negedge clk);
    check("b2b_cnt_a", 32'(count0), 1);
    wr_data0 = 8'hAA;
    @(negedge clk);
    check("b2b_cnt_b", 32'(count0), 1);
    wr_data0 = 8'h0F;
    @(negedge clk);
    check("b2b_cnt_c", 32'(count0), 2);
    wr_en0 = 1'b0;
    nb0 = 0;
    for (int i = 0; i < 140; i++) begin
      if (busy0) nb0++;
      @(negedge clk);
    end
    check("b2b_busy_len", nb0, 119);
    check("b2b_cnt_end",  32'(count0), 0);

    // Overflow while a frame holds the transmitter.
    wr_en0 = 1'b1; wr_data0 = 8'h3C;
    @(negedge clk);
    wr_en0 = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      wr_en0 = 1'b1; wr_data0 = 8'($urandom);
      @(negedge clk);
    end
    check("ovf_full",  32'(full0),     1);
    check("ovf_count", 32'(count0),    4);
    check("ovf_flag",  32'(overflow0), 1);
    // Keep writing across the frame end: the pop happens, the write does not.
    min_cnt = 99;
    for (int i = 0; i < 50; i++) begin
      wr_data0 = 8'($urandom);
      @(negedge clk);
      if (int'(count0) < min_cnt) min_cnt = int'(count0);
    end
    wr_en0 = 1'b0;
    check("pop_full_min_cnt", min_cnt, 3);
    idle_wait(600);
    check("ovf_sticky", 32'(overflow0), 1);

    // Reset in the middle of a frame with words queued.
    wr_en0 = 1'b1; wr_data0 = 8'hFF;
    @(negedge clk);
    wr_data0 = 8'h12;
    @(negedge clk);
    wr_data0 = 8'h34;
    @(negedge clk);
    wr_en0 = 1'b0;
    repeat (16) @(negedge clk);
    check("pre_rst_busy", 32'(busy0), 1);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_tx0",    32'(tx0),       1);
    check("mid_rst_count0", 32'(count0),    0);
    check("mid_rst_busy0",  32'(busy0),     0);
    check("mid_rst_empty0", 32'(empty0),    1);
    check("mid_rst_ovf0",   32'(overflow0), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    low_cnt = 0; nb0 = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!tx0) low_cnt++;
      if (busy0) nb0++;
    end
    check("post_rst_tx_low", low_cnt, 0);
    check("post_rst_busy",   nb0,     0);

    // Random traffic at several write rates on both builds.
    for (int seg = 0; seg < 4; seg++) begin
      int lim;
      lim = (seg == 0) ? 40 : (seg == 1) ? 12 : (seg == 2) ? 3 : 1;
      for (int i = 0; i < 600; i++) begin
        wr_en0   = ($urandom_range(0, lim) == 0);
        wr_data0 = 8'($urandom);
        wr_en1   = ($urandom_range(0, lim) == 0);
        wr_data1 = 7'($urandom);
        @(negedge clk);
      end
      wr_en0 = 1'b0; wr_en1 = 1'b0;
      if (seg == 1) idle_wait(1000);
    end
    idle_wait(2000);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
